echo_iteration_sequencer: RTL and testbench

- Synthesizable replacement for the delay-based per-sample control of the echo-cancellation chain.
- Once per sampling period it runs three stages in order, each as an enable pulse followed by a ready wait:
  - sig16b_to_double (conv)
  - lag_generator (lag)
  - para_approx (approx)
- Stages the sampling enables of lag/approx through a warm-up, counts completed iterations, and flags timeouts and overruns.

---
 rtl/echo_iteration_sequencer_if.sv | 19 +
 rtl/echo_iteration_sequencer.sv | 154 +++++++++++++++
 tb/tb_echo_iteration_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/echo_iteration_sequencer_if.sv
// Start/ready handshakes between the echo iteration sequencer and its three stages.
interface echo_iteration_sequencer_if;
  logic enable_conv;
  logic enable_lag;
  logic enable_approx;
  logic ready_conv;
  logic ready_lag;
  logic ready_approx;

  modport master (
    output enable_conv, enable_lag, enable_approx,
    input  ready_conv, ready_lag, ready_approx
  );

  modport slave (
    input  enable_conv, enable_lag, enable_approx,
    output ready_conv, ready_lag, ready_approx
  );
endinterface

// File: rtl/echo_iteration_sequencer.sv
// Per-sample conv -> lag -> approx pulse/ready sequencer with warm-up, iteration count and error flags.
// Optional statistics outputs (last_latency, timeout_count) are built when ECHO_SEQ_STATS_EN is defined.
module echo_iteration_sequencer #(
  parameter int unsigned CNT_W         = 13,
  parameter int unsigned PULSE_LEN     = 2,
  parameter int unsigned BLANK_LEN     = 2,
  parameter int unsigned TIMEOUT       = 1023,
  parameter int unsigned WARMUP_LAG    = 2,
  parameter int unsigned WARMUP_APPROX = 4,
  parameter int unsigned ITER_W        = 32
) (
  input  logic                     clk_operation,
  input  logic                     rst,
  input  logic                     run,
  input  logic [CNT_W-1:0]         sampling_cycle_counter,
  echo_iteration_sequencer_if.master stage_bus,
  output logic                     enable_sampling_lag,
  output logic                     enable_sampling_approx,
  output logic                     busy,
  output logic [ITER_W-1:0]        iteration,
  output logic                     timeout_err,
  output logic [1:0]               err_stage,
  output logic                     overrun
`ifdef ECHO_SEQ_STATS_EN
  ,
  output logic [15:0]              last_latency,
  output logic [7:0]               timeout_count
`endif
);

  localparam int unsigned TW = 12;
  localparam int unsigned WW = $clog2(WARMUP_APPROX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV_P, S_CONV_W, S_LAG_P, S_LAG_W, S_APPR_P, S_APPR_W, S_DONE
  } state_t;

  state_t            state_q, state_d, nxt_w;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     warm_q, warm_d;
  logic [ITER_W-1:0] iter_d;
  logic              tout_d, ovr_d, tout_evt, rdy_w, trig_c, pulse_end;
  logic [1:0]        err_d, code_w;
`ifdef ECHO_SEQ_STATS_EN
  logic [15:0]       lat_q, lat_d, last_d;
  logic [7:0]        tcnt_d;
`endif

  assign trig_c    = (sampling_cycle_counter == '0);
  assign pulse_end = (cnt_q == TW'(PULSE_LEN - 1));

  // Next-state and next-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + TW'(1);
    warm_d   = warm_q;
    iter_d   = iteration;
    tout_d   = timeout_err;
    err_d    = err_stage;
    ovr_d    = overrun;
    tout_evt = 1'b0;
    rdy_w    = 1'b0;
    nxt_w    = S_IDLE;
    code_w   = 2'd0;

    case (state_q)
      S_CONV_W: begin rdy_w = stage_bus.ready_conv;   nxt_w = S_LAG_P;  code_w = 2'd1; end
      S_LAG_W:  begin rdy_w = stage_bus.ready_lag;    nxt_w = S_APPR_P; code_w = 2'd2; end
      S_APPR_W: begin rdy_w = stage_bus.ready_approx; nxt_w = S_DONE;   code_w = 2'd3; end
      default:  ;
    endcase

    if (trig_c && warm_q != WW'(WARMUP_APPROX)) warm_d = warm_q + WW'(1);
    if (trig_c && state_q != S_IDLE)            ovr_d  = 1'b1;

    case (state_q)
      S_IDLE:   if (trig_c && run) state_d = S_CONV_P;
      S_CONV_P: if (pulse_end) state_d = S_CONV_W;
      S_LAG_P:  if (pulse_end) state_d = S_LAG_W;
      S_APPR_P: if (pulse_end) state_d = S_APPR_W;
      S_DONE: begin
        iter_d  = iteration + ITER_W'(1);
        state_d = S_IDLE;
      end
      default: begin
        // The pulse-ending edge plus the first wait edge form the blank window; ready beats timeout.
        if (cnt_q >= TW'(BLANK_LEN - 1) && rdy_w) begin
          state_d = nxt_w;
        end else if (cnt_q == TW'(BLANK_LEN + TIMEOUT - 2)) begin
          state_d  = S_IDLE;
          tout_d   = 1'b1;
          err_d    = code_w;
          tout_evt = 1'b1;
        end
      end
    endcase

    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;

`ifdef ECHO_SEQ_STATS_EN
    lat_d  = lat_q;
    last_d = last_latency;
    tcnt_d = timeout_count;
    if (state_q == S_IDLE && trig_c && run)        lat_d = 16'd1;
    else if (state_q != S_IDLE && lat_q != 16'hFFFF) lat_d = lat_q + 16'd1;
    if (state_q == S_DONE)                         last_d = lat_q;
    if (tout_evt && timeout_count != 8'hFF)        tcnt_d = timeout_count + 8'd1;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state_q                 <= S_IDLE;
      cnt_q                   <= '0;
      warm_q                  <= '0;
      iteration               <= '0;
      timeout_err             <= 1'b0;
      err_stage               <= 2'd0;
      overrun                 <= 1'b0;
      busy                    <= 1'b0;
      enable_sampling_lag     <= 1'b0;
      enable_sampling_approx  <= 1'b0;
      stage_bus.enable_conv   <= 1'b0;
      stage_bus.enable_lag    <= 1'b0;
      stage_bus.enable_approx <= 1'b0;
`ifdef ECHO_SEQ_STATS_EN
      lat_q                   <= '0;
      last_latency            <= '0;
      timeout_count           <= '0;
`endif
    end else begin
      state_q                 <= state_d;
      cnt_q                   <= cnt_d;
      warm_q                  <= warm_d;
      iteration               <= iter_d;
      timeout_err             <= tout_d;
      err_stage               <= err_d;
      overrun                 <= ovr_d;
      busy                    <= (state_d != S_IDLE);
      enable_sampling_lag     <= (warm_d >= WW'(WARMUP_LAG));
      enable_sampling_approx  <= (warm_d >= WW'(WARMUP_APPROX));
      stage_bus.enable_conv   <= (state_d == S_CONV_P);
      stage_bus.enable_lag    <= (state_d == S_LAG_P);
      stage_bus.enable_approx <= (state_d == S_APPR_P);
`ifdef ECHO_SEQ_STATS_EN
      lat_q                   <= lat_d;
      last_latency            <= last_d;
      timeout_count           <= tcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_echo_iteration_sequencer.sv
// Directed bench for echo_iteration_sequencer; stats checks are compiled in with ECHO_SEQ_STATS_EN.
module tb_echo_iteration_sequencer;

  logic        clk_operation = 1'b0;
  logic        rst;
  logic        run;
  logic [12:0] scc;
  logic        enable_sampling_lag, enable_sampling_approx, busy;
  logic [31:0] iteration;
  logic        timeout_err, overrun;
  logic [1:0]  err_stage;
`ifdef ECHO_SEQ_STATS_EN
  logic [15:0] last_latency;
  logic [7:0]  timeout_count;
`endif

  int total = 0;
  int bad   = 0;

  echo_iteration_sequencer_if bus ();

  echo_iteration_sequencer dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .run                    (run),
    .sampling_cycle_counter (scc),
    .stage_bus              (bus.master),
    .enable_sampling_lag    (enable_sampling_lag),
    .enable_sampling_approx (enable_sampling_approx),
    .busy                   (busy),
    .iteration              (iteration),
    .timeout_err            (timeout_err),
    .err_stage              (err_stage),
    .overrun                (overrun)
`ifdef ECHO_SEQ_STATS_EN
    ,
    .last_latency           (last_latency),
    .timeout_count          (timeout_count)
`endif
  );

  always #5 clk_operation = ~clk_operation;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_operation);
    #1;
  endtask

  task automatic trigger();
    scc = 13'd0;
    tick();
    scc = 13'd5;
  endtask

  function automatic logic en(input int s);
    case (s)
      0:       return bus.enable_conv;
      1:       return bus.enable_lag;
      default: return bus.enable_approx;
    endcase
  endfunction

  task automatic set_ready(input int s, input logic v);
    case (s)
      0:       bus.ready_conv   = v;
      1:       bus.ready_lag    = v;
      default: bus.ready_approx = v;
    endcase
  endtask

  // Wait for the stage pulse, measure it, and leave the bench in the first cycle after it.
  task automatic pulse(input int s);
    int guard = 0;
    int width = 0;
    while (!en(s) && guard < 40) begin tick(); guard++; end
    chk($sformatf("start_delay_s%0d", s), 32'(guard), 32'd0);
    chk($sformatf("onehot_s%0d", s),
        32'({bus.enable_approx, bus.enable_lag, bus.enable_conv}), 32'(1 << s));
    while (en(s) && width < 40) begin tick(); width++; end
    chk($sformatf("pulse_width_s%0d", s), 32'(width), 32'd2);
  endtask

  // Ready is seen by the DUT on the d-th edge after the pulse-ending edge.
  task automatic stage(input int s, input int d);
    pulse(s);
    repeat (d - 1) tick();
    set_ready(s, 1'b1);
    tick();
    set_ready(s, 1'b0);
  endtask

  task automatic wait_timeout(input string tag, input logic [1:0] code);
    int  n = 0;
    bit  saw_approx = 0;
    while (busy && n < 1100) begin
      tick();
      n++;
      if (bus.enable_approx) saw_approx = 1;
    end
    chk({tag, "_cycles"}, 32'(n), 32'd1024);
    chk({tag, "_err"}, 32'(timeout_err), 32'd1);
    chk({tag, "_stage"}, 32'(err_stage), 32'(code));
    chk({tag, "_no_approx"}, 32'(saw_approx), 32'd0);
  endtask

  task automatic full_iter(input string tag, input int d, input logic [31:0] it_after);
    for (int s = 0; s < 3; s++) stage(s, d);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_iter_done"}, iteration, it_after - 32'd1);
    tick();
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_iter"}, iteration, it_after);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; scc = 13'd5;
    bus.ready_conv = 1'b0; bus.ready_lag = 1'b0; bus.ready_approx = 1'b0;
    #3;
    chk("rst_flags", 32'({bus.enable_conv, bus.enable_lag, bus.enable_approx, enable_sampling_lag,
                          enable_sampling_approx, busy, timeout_err, err_stage, overrun}), 32'd0);
    chk("rst_iter", iteration, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Warm-up with run low: sampling enables stage in, nothing starts.
    for (int i = 1; i <= 5; i++) begin
      trigger();
      chk($sformatf("warm_lag_%0d", i), 32'(enable_sampling_lag), 32'(i >= 2));
      chk($sformatf("warm_approx_%0d", i), 32'(enable_sampling_approx), 32'(i >= 4));
      chk($sformatf("warm_busy_%0d", i), 32'(busy), 32'd0);
    end
    chk("warm_iter", iteration, 32'd0);

    // Nominal: readies three edges after each pulse end; DONE at cycle 15, idle at 16.
    run = 1'b1;
    trigger();
    chk("nom_busy_rise", 32'(busy), 32'd1);
    full_iter("nom", 3, 32'd1);
    chk("nom_flags", 32'({timeout_err, overrun}), 32'd0);

    // Earliest readies: minimum latency of 13 cycles.
    trigger();
    full_iter("min", 2, 32'd2);
`ifdef ECHO_SEQ_STATS_EN
    chk("min_latency", 32'(last_latency), 32'd13);
`endif

    // Lag stage never answers.
    trigger();
    stage(0, 2);
    pulse(1);
    wait_timeout("to_lag", 2'd2);
    chk("to_lag_iter", iteration, 32'd2);
    trigger();
    full_iter("after_to", 2, 32'd3);
    chk("after_to_sticky", 32'(timeout_err), 32'd1);

    // Conv stage never answers.
    trigger();
    pulse(0);
    wait_timeout("to_conv", 2'd1);
    chk("to_conv_iter", iteration, 32'd3);
`ifdef ECHO_SEQ_STATS_EN
    chk("timeout_count", 32'(timeout_count), 32'd2);
`endif

    // Overrun: a sample start lands while approx is still pending.
    trigger();
    stage(0, 2);
    stage(1, 2);
    pulse(2);
    chk("ovr_before", 32'(overrun), 32'd0);
    trigger();
    chk("ovr_set", 32'(overrun), 32'd1);
    set_ready(2, 1'b1);
    tick();
    set_ready(2, 1'b0);
    chk("ovr_done_busy", 32'(busy), 32'd1);
    tick();
    chk("ovr_iter", iteration, 32'd4);
    tick(); tick();
    chk("ovr_no_restart", 32'(busy), 32'd0);

    // run falls mid-iteration: finish this one, start no more.
    trigger();
    run = 1'b0;
    full_iter("runfall", 2, 32'd5);
    trigger();
    chk("runfall_no_start", 32'(busy), 32'd0);

    // Asynchronous reset while waiting in LAG_W.
    run = 1'b1;
    trigger();
    stage(0, 2);
    pulse(1);
    #2 rst = 1'b0;
    #1;
    chk("arst_flags", 32'({bus.enable_conv, bus.enable_lag, bus.enable_approx, enable_sampling_lag,
                           enable_sampling_approx, busy, timeout_err, err_stage, overrun}), 32'd0);
    chk("arst_iter", iteration, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_idle", 32'(busy), 32'd0);
    trigger();
    chk("arst_conv_start", 32'(bus.enable_conv), 32'd1);
    chk("arst_warm_lag", 32'(enable_sampling_lag), 32'd0);
    full_iter("arst_run", 2, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
